// File: rtl/gs_operand_store_if.sv
`default_nettype none
// ============================================================================
// Module      : gs_operand_store_if
// Description : Bus bundle between the Gauss-Seidel operand store and its
//               neighbours: the right-hand-side load port, the result return
//               from the computation unit, the issued operands and the
//               solution output stream.
//   in_en, b_in         : right-hand-side sample load (valid / 16-bit data)
//   x_in                : result returned by the computation unit
//   b_out, xm1..xp3     : operands of the issued equation
//   busy                : store is not idle
//   out_valid, x_out    : solution word stream x[0]..x[15]
// Modports    : master = the operand store, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface gs_operand_store_if;
  logic        in_en;
  logic [15:0] b_in;
  logic [31:0] x_in;
  logic [31:0] b_out;
  logic [31:0] xm1;
  logic [31:0] xp1;
  logic [31:0] xm2;
  logic [31:0] xp2;
  logic [31:0] xm3;
  logic [31:0] xp3;
  logic        busy;
  logic        out_valid;
  logic [31:0] x_out;

  modport master (
    input  in_en, b_in, x_in,
    output b_out, xm1, xp1, xm2, xp2, xm3, xp3, busy, out_valid, x_out
  );

  modport slave (
    output in_en, b_in, x_in,
    input  b_out, xm1, xp1, xm2, xp2, xm3, xp3, busy, out_valid, x_out
  );
endinterface
`default_nettype wire

// File: rtl/gs_operand_store.sv
`default_nettype none
// ============================================================================
// Module      : gs_operand_store
// Description : Operand store and sequencer of the 16-unknown Gauss-Seidel
//               solver. Captures b[0..15], issues one equation per cycle to
//               the single-register computation unit, writes each result back
//               and streams x[0..15] out after the last sweep.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - gs_operand_store_if.master (load, result return,
//                          operands, busy, solution stream)
// Parameters  : ITER      - sweeps to run (1..63)
//               FRAC_BITS - fractional bits of x; b_out is aligned to it
// Options     : GS_EARLY_STOP_EN - when defined, stop after the first sweep
//               (s>=1) whose write-backs of x[0..14] leave x unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module gs_operand_store #(
  parameter int ITER      = 50,
  parameter int FRAC_BITS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  gs_operand_store_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  localparam logic [5:0] C_LAST_SWEEP = 6'(ITER - 1);

  state_e      state_q, state_d;
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [3:0]  idx_q, idx_d;          // index issued this cycle
  logic [5:0]  sweep_q, sweep_d;
  logic [3:0]  out_cnt_q, out_cnt_d;  // index of the word on x_out
  logic        wb_vld_q, wb_vld_d;    // an issue happened last cycle
  logic [3:0]  wb_idx_q, wb_idx_d;    // index that x_in belongs to
  logic [15:0] b_q [16];
  logic [15:0] b_d [16];
  logic [31:0] x_q [16];
  logic [31:0] x_d [16];
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] x_out_q, x_out_d;

  logic        w_last_issue;
  logic [31:0] w_b_ext;

`ifdef GS_EARLY_STOP_EN
  logic        chg_q, chg_d;
  logic        w_wb_diff;

  // The x[15] write-back landing at i=0 belongs to the previous sweep and is
  // swallowed by the clear; the x[14] write-back happening alongside the i=15
  // issue is folded into the decision combinationally.
  always_comb begin
    w_wb_diff    = wb_vld_q && (bus.x_in != x_q[wb_idx_q]);
    w_last_issue = (idx_q == 4'd15) &&
                   ((sweep_q == C_LAST_SWEEP) ||
                    ((sweep_q != 6'd0) && !(chg_q || w_wb_diff)));
  end
`else
  always_comb begin
    w_last_issue = (idx_q == 4'd15) && (sweep_q == C_LAST_SWEEP);
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    idx_d       = idx_q;
    sweep_d     = sweep_q;
    out_cnt_d   = out_cnt_q;
    wb_vld_d    = 1'b0;
    wb_idx_d    = wb_idx_q;
    b_d         = b_q;
    x_d         = x_q;
    out_valid_d = 1'b0;
    x_out_d     = '0;
`ifdef GS_EARLY_STOP_EN
    chg_d       = chg_q;
`endif

    // Result of last cycle's issue; only RUN sets wb_vld, so this covers
    // every RUN cycle after the first and the single DRAIN cycle.
    if (wb_vld_q) begin
      x_d[wb_idx_q] = bus.x_in;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_en) begin
          b_d[0]   = bus.b_in;
          ld_cnt_d = 4'd1;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (bus.in_en) begin
          b_d[ld_cnt_q] = bus.b_in;
          ld_cnt_d      = ld_cnt_q + 4'd1;
          if (ld_cnt_q == 4'd15) begin
            state_d  = S_RUN;
            ld_cnt_d = 4'd0;
            idx_d    = 4'd0;
            sweep_d  = 6'd0;
            for (int j = 0; j < 16; j++) begin
              x_d[j] = '0;
            end
          end
        end
      end

      S_RUN: begin
        wb_vld_d = 1'b1;
        wb_idx_d = idx_q;
`ifdef GS_EARLY_STOP_EN
        chg_d = (idx_q == 4'd0) ? 1'b0 : (chg_q | w_wb_diff);
`endif
        if (w_last_issue) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            sweep_d = sweep_q + 6'd1;
          end
        end
      end

      S_DRAIN: begin
        // x[0] is stable here; only x[15] is being written back.
        state_d     = S_OUT;
        out_cnt_d   = 4'd0;
        out_valid_d = 1'b1;
        x_out_d     = x_q[0];
      end

      S_OUT: begin
        if (out_cnt_q == 4'd15) begin
          state_d = S_IDLE;
        end else begin
          out_cnt_d   = out_cnt_q + 4'd1;
          out_valid_d = 1'b1;
          x_out_d     = x_q[out_cnt_q + 4'd1];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      idx_q       <= '0;
      sweep_q     <= '0;
      out_cnt_q   <= '0;
      wb_vld_q    <= 1'b0;
      wb_idx_q    <= '0;
      b_q         <= '{default: '0};
      x_q         <= '{default: '0};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
`ifdef GS_EARLY_STOP_EN
      chg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      idx_q       <= idx_d;
      sweep_q     <= sweep_d;
      out_cnt_q   <= out_cnt_d;
      wb_vld_q    <= wb_vld_d;
      wb_idx_q    <= wb_idx_d;
      b_q         <= b_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
`ifdef GS_EARLY_STOP_EN
      chg_q       <= chg_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Operand ports: combinational from storage, plus x_in for xm1 because the
  // result for i-1 has not been written back yet when i issues.
  // --------------------------------------------------------------------------
  always_comb begin
    w_b_ext   = {{16{b_q[idx_q][15]}}, b_q[idx_q]};
    bus.b_out = '0;
    bus.xm1   = '0;
    bus.xm2   = '0;
    bus.xm3   = '0;
    bus.xp1   = '0;
    bus.xp2   = '0;
    bus.xp3   = '0;
    if (state_q == S_RUN) begin
      bus.b_out = w_b_ext << FRAC_BITS;
      if (idx_q >= 4'd1)  bus.xm1 = bus.x_in;
      if (idx_q >= 4'd2)  bus.xm2 = x_q[idx_q - 4'd2];
      if (idx_q >= 4'd3)  bus.xm3 = x_q[idx_q - 4'd3];
      if (idx_q <= 4'd14) bus.xp1 = x_q[idx_q + 4'd1];
      if (idx_q <= 4'd13) bus.xp2 = x_q[idx_q + 4'd2];
      if (idx_q <= 4'd12) bus.xp3 = x_q[idx_q + 4'd3];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;

endmodule
`default_nettype wire

// File: tb/tb_gs_operand_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_gs_operand_store
// Description : Self-checking bench for gs_operand_store. Two instances
//               (ITER=2 and ITER=50) share clock and reset; a stub stands in
//               for the computation unit and expected solution words are
//               queued when a load starts and popped as x_out appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gs_operand_store;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sel     = 1'b0;   // 0: ITER=2 instance, 1: ITER=50 instance

  logic        tb_in_en = 1'b0;
  logic [15:0] tb_b_in  = '0;
  logic [31:0] tb_x_in  = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  gs_operand_store_if if2 ();
  gs_operand_store_if if50 ();

  assign if2.in_en  = tb_in_en & ~sel;
  assign if2.b_in   = tb_b_in;
  assign if2.x_in   = sel ? 32'd0 : tb_x_in;
  assign if50.in_en = tb_in_en & sel;
  assign if50.b_in  = tb_b_in;
  assign if50.x_in  = sel ? tb_x_in : 32'd0;

  gs_operand_store #(.ITER(2), .FRAC_BITS(16)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if2.master)
  );

  gs_operand_store #(.ITER(50), .FRAC_BITS(16)) u_dut50 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if50.master)
  );

  always #5 clk = ~clk;

  logic [31:0] ob_b_out, ob_xm1, ob_xm2, ob_xm3, ob_xp1, ob_xp2, ob_xp3, ob_x_out;
  logic        ob_busy, ob_out_valid;

  assign ob_b_out     = sel ? if50.b_out     : if2.b_out;
  assign ob_xm1       = sel ? if50.xm1       : if2.xm1;
  assign ob_xm2       = sel ? if50.xm2       : if2.xm2;
  assign ob_xm3       = sel ? if50.xm3       : if2.xm3;
  assign ob_xp1       = sel ? if50.xp1       : if2.xp1;
  assign ob_xp2       = sel ? if50.xp2       : if2.xp2;
  assign ob_xp3       = sel ? if50.xp3       : if2.xp3;
  assign ob_x_out     = sel ? if50.x_out     : if2.x_out;
  assign ob_busy      = sel ? if50.busy      : if2.busy;
  assign ob_out_valid = sel ? if50.out_valid : if2.out_valid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stub computation unit: result for the index issued in the previous cycle.
  // mode 0: zero, mode 1: 0x100 + index, mode 2: constant 0x1234.
  function automatic logic [31:0] stub(input int mode, input int t);
    int prev;
    if (t == 0) return 32'd0;
    prev = (t - 1) % 16;
    case (mode)
      1:       return 32'h100 + 32'(prev);
      2:       return 32'h1234;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_x(input int mode, input int k);
    case (mode)
      1:       return 32'h100 + 32'(k);
      2:       return 32'h1234;
      default: return 32'd0;
    endcase
  endfunction

  // One full load + solve. Cycle t=0 is the cycle after the edge storing b[15].
  task automatic run_case(input bit use50, input int mode, input int bpat,
                          input int gap_after, input int drain_cyc, input int abort_at);
    logic [15:0] bv [16];
    logic [31:0] eb;
    exp_t        e;
    int          last_out;

    sel = use50;
    for (int k = 0; k < 16; k++) begin
      bv[k] = (bpat == 0) ? 16'(k) : 16'(-37 * (k + 1));
    end
    sb.delete();
    for (int k = 0; k < 16; k++) begin
      e.cyc = drain_cyc + 1 + k;
      e.val = model_x(mode, k);
      sb.push_back(e);
    end
    last_out = drain_cyc + 16;

    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      tb_in_en = 1'b1;
      tb_b_in  = bv[k];
      @(posedge clk); #1;
      tb_in_en = 1'b0;
      if (k == gap_after) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end

    for (int t = 0; t <= last_out + 1; t++) begin
      tb_x_in = stub(mode, t);
      if (t == abort_at) begin
        reset_n = 1'b0;
        @(negedge clk);
        check_val("rst_busy",      32'(ob_busy),      32'd0);
        check_val("rst_out_valid", 32'(ob_out_valid), 32'd0);
        check_val("rst_x_out",     ob_x_out,          32'd0);
        check_val("rst_b_out",     ob_b_out,          32'd0);
        check_val("rst_xm1",       ob_xm1,            32'd0);
        check_val("rst_xm2",       ob_xm2,            32'd0);
        check_val("rst_xm3",       ob_xm3,            32'd0);
        check_val("rst_xp1",       ob_xp1,            32'd0);
        check_val("rst_xp2",       ob_xp2,            32'd0);
        check_val("rst_xp3",       ob_xp3,            32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        return;
      end
      @(negedge clk);
      if (t < 16) begin
        eb = {{16{bv[t][15]}}, bv[t]} << 16;
        check_val("b_out", ob_b_out, eb);
      end
      if (t == 0) check_val("busy_c0", 32'(ob_busy), 32'd1);
      if (!use50 && mode == 1) begin
        if (t == 5) begin
          check_val("s0_xm1", ob_xm1, 32'h104);
          check_val("s0_xm2", ob_xm2, 32'h103);
          check_val("s0_xp1", ob_xp1, 32'h0);
          check_val("s0_xp3", ob_xp3, 32'h0);
        end
        if (t == 16) begin
          check_val("i0_xm1", ob_xm1, 32'h0);
          check_val("i0_xm2", ob_xm2, 32'h0);
          check_val("i0_xm3", ob_xm3, 32'h0);
          check_val("i0_xp1", ob_xp1, 32'h101);
        end
        if (t == 21) begin
          check_val("i5_b_out", ob_b_out, 32'h0005_0000);
          check_val("i5_xm1",   ob_xm1,   32'h104);
          check_val("i5_xm2",   ob_xm2,   32'h103);
          check_val("i5_xm3",   ob_xm3,   32'h102);
          check_val("i5_xp1",   ob_xp1,   32'h106);
          check_val("i5_xp2",   ob_xp2,   32'h107);
          check_val("i5_xp3",   ob_xp3,   32'h108);
        end
        if (t == 30) begin
          check_val("i14_xp1", ob_xp1, 32'h10F);
          check_val("i14_xp2", ob_xp2, 32'h0);
          check_val("i14_xp3", ob_xp3, 32'h0);
        end
        if (t == 31) begin
          check_val("i15_xm1", ob_xm1, 32'h10E);
          check_val("i15_xp1", ob_xp1, 32'h0);
          check_val("i15_xp2", ob_xp2, 32'h0);
          check_val("i15_xp3", ob_xp3, 32'h0);
        end
      end
      if (ob_out_valid) begin
        if (sb.size() == 0) begin
          check_val("out_extra", 32'(ob_out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("out_cycle", 32'(t), 32'(e.cyc));
          check_val("x_out",     ob_x_out, e.val);
        end
      end
      if (t == last_out)     check_val("busy_last_out", 32'(ob_busy), 32'd1);
      if (t == last_out + 1) check_val("busy_after",    32'(ob_busy), 32'd0);
      @(posedge clk); #1;
    end
    check_val("out_missing", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int es_drain;
`ifdef GS_EARLY_STOP_EN
    es_drain = 32;
`else
    es_drain = 800;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("reset_busy",      32'(ob_busy),      32'd0);
    check_val("reset_out_valid", 32'(ob_out_valid), 32'd0);
    check_val("reset_x_out",     ob_x_out,          32'd0);

    // reset in the middle of RUN
    run_case(1'b0, 0, 1, -1, 32, 10);
    // zero system
    run_case(1'b0, 0, 0, -1, 32, -1);
    // load gap of 3 cycles between samples 7 and 8, negative b values
    run_case(1'b0, 2, 1, 7, 32, -1);
    // operand / boundary run; x left at 0x1234 by the previous run
    run_case(1'b0, 1, 0, -1, 32, -1);
    // constant result stream on the ITER=50 instance
    run_case(1'b1, 2, 0, -1, es_drain, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
